// File: rtl/pixel_sram_pkg.sv
// Shared types and helpers for the pixel memory: fill FSM states, default widths,
// and the per-channel mask merge used by both the array write and the read bypass.
package pixel_sram_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_CH_W   = 8;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DEPTH  = 128;

  // Widest word/channel count the merge helper handles; callers cast in and out.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_NCH    = 16;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_NCH-1:0]    chmask_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  function automatic word_t mask_merge(word_t old_w, word_t new_w, chmask_t mask, int ch_w);
    word_t res;
    res = old_w;
    for (int c = 0; c < MAX_NCH; c++) begin
      for (int b = 0; b < MAX_DATA_W; b++) begin
        if (mask[c] && (b >= c * ch_w) && (b < (c + 1) * ch_w)) res[b] = new_w[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_sram_if.sv
// Write, read and fill signals of the pixel memory; master drives requests,
// slave (the memory) returns read data and fill status. No flow control.
interface pixel_sram_if
  import pixel_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NCH    = DEF_DATA_W / DEF_CH_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NCH-1:0]    wr_mask;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              fill_start;
  logic [DATA_W-1:0] fill_data;
  logic              busy;
  logic              fill_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, fill_start, fill_data,
    input  rd_data, rd_valid, busy, fill_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, fill_start, fill_data,
    output rd_data, rd_valid, busy, fill_done
  );

endinterface

// File: rtl/sram_fill_ctrl.sv
// Fill engine: latches a colour and sweeps every address once, one word per cycle.
// Busy for DEPTH cycles, then a one-cycle done pulse; starts are ignored until idle.
module sram_fill_ctrl
  import pixel_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fw_en,
  output logic [ADDR_W-1:0] fw_addr,
  output logic [DATA_W-1:0] fw_data,
  output logic              busy,
  output logic              fill_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] color, color_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      color <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      color <= color_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    color_nxt = color;
    fw_en     = 1'b0;
    busy      = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
          color_nxt = fill_data;
        end
      end
      FILL: begin
        fw_en = 1'b1;
        busy  = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = DONE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      DONE: begin
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fw_addr = cnt;
  assign fw_data = color;

endmodule

// File: rtl/pixel_sram.sv
// Pixel memory with masked writes, 1-cycle registered write-first reads and a fill engine.
// No stalls: reads/writes every cycle; external writes are dropped while a fill runs.
module pixel_sram
  import pixel_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = DEF_CH_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       n_rst,
  pixel_sram_if.slave bus
);

  localparam int              NCH     = DATA_W / CH_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fw_en;
  logic [ADDR_W-1:0] fw_addr;
  logic [DATA_W-1:0] fw_data;

  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NCH-1:0]    w_mask;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_word;
  logic              w_hit;
  logic              rd_ok;

  sram_fill_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fill (
    .clk        (clk),
    .n_rst      (n_rst),
    .fill_start (bus.fill_start),
    .fill_data  (bus.fill_data),
    .fw_en      (fw_en),
    .fw_addr    (fw_addr),
    .fw_data    (fw_data),
    .busy       (bus.busy),
    .fill_done  (bus.fill_done)
  );

  // Fill owns the write port for its whole sweep, so the external write loses.
  always_comb begin
    w_en   = 1'b0;
    w_addr = bus.wr_addr;
    w_data = bus.wr_data;
    w_mask = bus.wr_mask;
    if (fw_en) begin
      w_en   = 1'b1;
      w_addr = fw_addr;
      w_data = fw_data;
      w_mask = '1;
    end else if (bus.wr_en) begin
      w_en = 1'b1;
    end
  end

  assign w_hit  = w_en && ({1'b0, w_addr} < DEPTH_L);
  assign rd_ok  = {1'b0, bus.rd_addr} < DEPTH_L;
  assign w_old  = mem[w_addr];
  assign w_word = DATA_W'(mask_merge(word_t'(w_old), word_t'(w_data), chmask_t'(w_mask), CH_W));

  always_ff @(posedge clk) begin
    if (w_hit) mem[w_addr] <= w_word;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        if (!rd_ok)                             bus.rd_data <= '0;
        else if (w_hit && w_addr == bus.rd_addr) bus.rd_data <= w_word;
        else                                    bus.rd_data <= mem[bus.rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_pixel_sram.sv
// Randomised bench for pixel_sram against a word-array reference model,
// plus directed masked-write, collision, fill, reset-abort and out-of-range cases.
module tb_pixel_sram;

  localparam int DEPTH  = 128;
  localparam int DEPTH2 = 100;

  logic clk = 1'b0;
  logic n_rst1, n_rst2;
  always #5 clk = ~clk;

  pixel_sram_if #(.DATA_W(24), .ADDR_W(7), .NCH(3)) b1 ();
  pixel_sram_if #(.DATA_W(24), .ADDR_W(7), .NCH(3)) b2 ();

  pixel_sram #(.DATA_W(24), .CH_W(8), .ADDR_W(7), .DEPTH(DEPTH))  dut1 (.clk(clk), .n_rst(n_rst1), .bus(b1));
  pixel_sram #(.DATA_W(24), .CH_W(8), .ADDR_W(7), .DEPTH(DEPTH2)) dut2 (.clk(clk), .n_rst(n_rst2), .bus(b2));

  // Reference model: word contents plus which bits have ever been written.
  logic [23:0] mdl_mem   [DEPTH];
  logic [23:0] mdl_known [DEPTH];
  logic [23:0] exp_rd, exp_known;
  logic        exp_vld;
  bit          m_busy, m_done;
  int          m_idx;
  logic [23:0] m_color;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle1();
    b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.wr_mask = '0;
    b1.rd_en = 1'b0; b1.rd_addr = '0; b1.fill_start = 1'b0; b1.fill_data = '0;
  endtask

  task automatic idle2();
    b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0; b2.wr_mask = '0;
    b2.rd_en = 1'b0; b2.rd_addr = '0; b2.fill_start = 1'b0; b2.fill_data = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_idx = 0;
    exp_rd = '0; exp_known = '1; exp_vld = 1'b0;
  endtask

  // Apply this cycle's inputs to the model, clock once, then compare outputs.
  task automatic tick1();
    int          a, ra;
    logic [2:0]  mk;
    logic [23:0] d;
    bit          do_w;
    do_w = 0; a = 0; mk = '0; d = '0;
    if (m_busy) begin
      do_w = 1; a = m_idx; d = m_color; mk = 3'b111;
    end else if (b1.wr_en) begin
      do_w = 1; a = int'(b1.wr_addr); d = b1.wr_data; mk = b1.wr_mask;
    end
    if (do_w && a < DEPTH) begin
      for (int c = 0; c < 3; c++) begin
        if (mk[c]) begin
          mdl_mem[a][c*8 +: 8]   = d[c*8 +: 8];
          mdl_known[a][c*8 +: 8] = 8'hFF;
        end
      end
    end
    exp_vld = b1.rd_en;
    if (b1.rd_en) begin
      ra = int'(b1.rd_addr);
      if (ra >= DEPTH) begin
        exp_rd = '0; exp_known = '1;
      end else begin
        exp_rd = mdl_mem[ra]; exp_known = mdl_known[ra];
      end
    end
    if (m_busy) begin
      if (m_idx == DEPTH - 1) begin m_busy = 0; m_done = 1; end
      else m_idx++;
    end else if (m_done) begin
      m_done = 0;
    end else if (b1.fill_start) begin
      m_busy = 1; m_idx = 0; m_color = b1.fill_data;
    end
    @(posedge clk); #1;
    check("busy", 32'(b1.busy), 32'(m_busy));
    check("fill_done", 32'(b1.fill_done), 32'(m_done));
    check("rd_valid", 32'(b1.rd_valid), 32'(exp_vld));
    if (exp_known != '0) check("rd_data", 32'(b1.rd_data & exp_known), 32'(exp_rd & exp_known));
  endtask

  task automatic read1(input logic [6:0] addr, input logic [23:0] want, input string tag);
    b1.rd_en = 1'b1; b1.rd_addr = addr;
    tick1();
    b1.rd_en = 1'b0;
    check(tag, 32'(b1.rd_data), 32'(want));
  endtask

  task automatic write1(input logic [6:0] addr, input logic [23:0] data, input logic [2:0] mask);
    b1.wr_en = 1'b1; b1.wr_addr = addr; b1.wr_data = data; b1.wr_mask = mask;
    tick1();
    b1.wr_en = 1'b0;
  endtask

  // Run a whole fill on dut1 and confirm its exact busy length and single done pulse.
  task automatic fill1(input logic [23:0] color, input bit poke_addr3);
    int busy_cnt, done_cnt;
    b1.fill_start = 1'b1; b1.fill_data = color;
    tick1();
    b1.fill_start = 1'b0;
    busy_cnt = b1.busy ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 140; i++) begin
      b1.rd_en      = 1'($urandom_range(0, 1));
      b1.rd_addr    = 7'($urandom_range(0, 127));
      b1.fill_start = (i < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      b1.fill_data  = 24'($urandom);
      b1.wr_en      = poke_addr3 && (i == 5);
      b1.wr_addr    = 7'd3; b1.wr_data = 24'hABCDEF; b1.wr_mask = 3'b111;
      tick1();
      if (b1.busy)      busy_cnt++;
      if (b1.fill_done) done_cnt++;
    end
    idle1();
    check("busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = '0; mdl_known[i] = '0; end
    m_color = '0;
    idle1(); idle2();
    n_rst1 = 1'b0; n_rst2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", 32'(b1.rd_data), 32'd0);
    check("rst_rd_valid", 32'(b1.rd_valid), 32'd0);
    check("rst_busy", 32'(b1.busy), 32'd0);
    check("rst_fill_done", 32'(b1.fill_done), 32'd0);
    @(negedge clk);
    n_rst1 = 1'b1; n_rst2 = 1'b1;

    // Unwritten word: only the valid flag is defined.
    b1.rd_en = 1'b1; b1.rd_addr = 7'd5;
    tick1();
    b1.rd_en = 1'b0;

    write1(7'd5, 24'hA1B2C3, 3'b111);
    read1(7'd5, 24'hA1B2C3, "wr_rd_addr5");

    write1(7'd9, 24'h112233, 3'b111);
    write1(7'd9, 24'hFFFFFF, 3'b010);
    read1(7'd9, 24'h11FF33, "masked_addr9");

    write1(7'd20, 24'h000000, 3'b111);
    b1.wr_en = 1'b1; b1.wr_addr = 7'd20; b1.wr_data = 24'h123456; b1.wr_mask = 3'b101;
    b1.rd_en = 1'b1; b1.rd_addr = 7'd20;
    tick1();
    idle1();
    check("collision_addr20", 32'(b1.rd_data), 32'h120056);

    for (int i = 0; i < 300; i++) begin
      b1.wr_en   = 1'($urandom_range(0, 1));
      b1.wr_addr = 7'($urandom_range(0, 31));
      b1.wr_data = 24'($urandom);
      b1.wr_mask = 3'($urandom_range(0, 7));
      b1.rd_en   = 1'($urandom_range(0, 1));
      b1.rd_addr = ($urandom_range(0, 3) == 0) ? b1.wr_addr : 7'($urandom_range(0, 31));
      tick1();
    end
    idle1();

    fill1(24'h0000FF, 1'b1);
    read1(7'd0,   24'h0000FF, "fill_addr0");
    read1(7'd64,  24'h0000FF, "fill_addr64");
    read1(7'd127, 24'h0000FF, "fill_addr127");
    read1(7'd3,   24'h0000FF, "fill_addr3_wr_lost");

    // Abort a fill after 40 written words with an asynchronous reset.
    b1.fill_start = 1'b1; b1.fill_data = 24'h00FF00;
    tick1();
    b1.fill_start = 1'b0;
    repeat (40) tick1();
    n_rst1 = 1'b0;
    #1;
    for (int i = 0; i < m_idx; i++) begin mdl_mem[i] = 24'h00FF00; mdl_known[i] = '1; end
    model_reset();
    check("abort_busy", 32'(b1.busy), 32'd0);
    check("abort_fill_done", 32'(b1.fill_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    n_rst1 = 1'b1;
    #1;
    read1(7'd10, 24'h00FF00, "abort_addr10");
    fill1(24'h102030, 1'b0);
    read1(7'd50, 24'h102030, "refill_addr50");

    // Shallow instance: out-of-range write and read.
    b2.fill_start = 1'b1; b2.fill_data = 24'h00AA55;
    @(posedge clk); #1;
    b2.fill_start = 1'b0;
    for (int i = 0; i < 200 && !b2.fill_done; i++) begin
      @(posedge clk); #1;
    end
    check("d2_fill_done", 32'(b2.fill_done), 32'd1);
    @(posedge clk); #1;
    b2.wr_en = 1'b1; b2.wr_addr = 7'd110; b2.wr_data = 24'hFFFFFF; b2.wr_mask = 3'b111;
    @(posedge clk); #1;
    idle2();
    b2.rd_en = 1'b1; b2.rd_addr = 7'd110;
    @(posedge clk); #1;
    check("oor_rd_data", 32'(b2.rd_data), 32'd0);
    check("oor_rd_valid", 32'(b2.rd_valid), 32'd1);
    for (int a = 0; a < DEPTH2; a++) begin
      b2.rd_addr = 7'(a);
      @(posedge clk); #1;
      check("oor_inrange_word", 32'(b2.rd_data), 32'h00AA55);
    end
    idle2();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
